// File: rtl/boot_loader.sv
// Byte-stream program loader: writes a framed image into MEMORY while holding the cpu in reset.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte after the payload.
module boot_loader #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              R,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              cpu_r,
  output logic              done,
  output logic              err
);

  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [7:0] {
    st_addr_lo = 8'b0000_0001,
    st_addr_hi = 8'b0000_0010,
    st_len_lo  = 8'b0000_0100,
    st_len_hi  = 8'b0000_1000,
    st_data    = 8'b0001_0000,
    st_check   = 8'b0010_0000,
    st_run     = 8'b0100_0000,
    st_error   = 8'b1000_0000
  } state_t;

  state_t            state;
  logic [7:0]        addr_lo_r;
  logic [7:0]        len_lo_r;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] rem;
  logic [IDLE_W-1:0] idle;
  logic              xfer;
  logic              counting;
  logic              timeout_hit;
  state_t            end_st;

  // State following the payload (or an empty payload).
  function automatic state_t payload_end_state();
`ifdef LOADER_CHECKSUM_EN
    return st_check;
`else
    return st_run;
`endif
  endfunction

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] acc;
  logic [7:0] chk_sum;
  assign chk_sum = acc + rx_data;
`endif

  assign rx_ready = (state != st_run) && (state != st_error);

  always_comb begin
    xfer        = rx_valid && rx_ready;
    end_st      = payload_end_state();
    counting    = (TIMEOUT > 0) &&
                  (state inside {st_addr_hi, st_len_lo, st_len_hi, st_data, st_check});
    timeout_hit = counting && !xfer && (idle == IDLE_LAST);
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state    <= st_addr_lo;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= 8'h00;
      cpu_r    <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      idle     <= '0;
`ifdef LOADER_CHECKSUM_EN
      acc      <= 8'h00;
`endif
    end else begin
      mem_we <= 1'b0;
      if (xfer)
        idle <= '0;
      else if (counting)
        idle <= idle + IDLE_W'(1);

      case (state)
        st_addr_lo: if (xfer) begin
          addr_lo_r <= rx_data;
          state     <= st_addr_hi;
        end
        st_addr_hi: if (xfer) begin
          cur   <= ADDR_W'({rx_data, addr_lo_r});
          state <= st_len_lo;
        end
        st_len_lo: if (xfer) begin
          len_lo_r <= rx_data;
          state    <= st_len_hi;
        end
        st_len_hi: if (xfer) begin
          rem <= ADDR_W'({rx_data, len_lo_r});
          if ({rx_data, len_lo_r} == 16'h0000) begin
            state <= end_st;
            if (end_st == st_run) begin
              cpu_r <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            state <= st_data;
          end
        end
        // Write is registered here, so it reaches MEMORY no later than the release.
        st_data: if (xfer) begin
          mem_we   <= 1'b1;
          mem_addr <= cur;
          mem_din  <= rx_data;
          cur      <= cur + ADDR_W'(1);
          rem      <= rem - ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
          acc      <= acc + rx_data;
`endif
          if (rem == ADDR_W'(1)) begin
            state <= end_st;
            if (end_st == st_run) begin
              cpu_r <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        st_check: if (xfer) begin
          if (chk_sum == 8'h00) begin
            state <= st_run;
            cpu_r <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= st_error;
            err   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase

      if (timeout_hit) begin
        state <= st_error;
        err   <= 1'b1;
        cpu_r <= 1'b1;
        done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected memory writes are queued as frames are sent
// and popped by a monitor whenever mem_we is seen.
module tb_boot_loader;

  logic        CLK = 1'b0;
  logic        R;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        cpu_r;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];
  logic [23:0] exp_w;
  logic [7:0]  pay_q[$];

  localparam logic [27:0] RESET_VEC = {1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};

  always #5 CLK = ~CLK;

  boot_loader #(.ADDR_W(16), .TIMEOUT(4)) dut (
    .CLK(CLK), .R(R), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .cpu_r(cpu_r), .done(done), .err(err)
  );

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge CLK) begin
    if (mem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL mem_write unexpected: got addr=%h din=%h, none expected", mem_addr, mem_din);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_addr, mem_din} !== exp_w) begin
          bad++;
          $display("FAIL mem_write: got addr=%h din=%h, expected addr=%h din=%h",
                   mem_addr, mem_din, exp_w[23:8], exp_w[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    R        = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
    R = 1'b0;
  endtask

  // Sends header + pay_q (+ checksum), queues expected writes, checks the last write timing.
  task automatic send_frame(input logic [15:0] a, input string name);
    logic [15:0] ad;
    logic [15:0] len;
    logic [7:0]  sum;
    ad  = a;
    len = 16'(pay_q.size());
    sum = 8'h00;
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    foreach (pay_q[i]) begin
      exp_q.push_back({ad, pay_q[i]});
      sum = sum + pay_q[i];
      send_byte(pay_q[i]);
      if (i == pay_q.size() - 1) begin
        total++;
        if ({mem_we, mem_addr, mem_din} !== {1'b1, ad, pay_q[i]}) begin
          bad++;
          $display("FAIL %s last_write: got we=%b addr=%h din=%h, expected we=1 addr=%h din=%h",
                   name, mem_we, mem_addr, mem_din, ad, pay_q[i]);
        end
      end
      ad = ad + 16'd1;
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00 - sum);
`endif
    total++;
    if ({cpu_r, done, err, rx_ready} !== 4'b0100) begin
      bad++;
      $display("FAIL %s release: got cpu_r=%b done=%b err=%b rx_ready=%b, expected 0 1 0 0",
               name, cpu_r, done, err, rx_ready);
    end
  endtask

  task automatic check_drained(input string name);
    tick();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s drained: got %0d pending writes, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mem_we, mem_addr, mem_din, cpu_r, done, err, rx_ready} !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_values: got %h, expected %h",
               {mem_we, mem_addr, mem_din, cpu_r, done, err, rx_ready}, RESET_VEC);
    end
    repeat (10) tick();
    total++;
    if ({err, cpu_r, rx_ready} !== 3'b011) begin
      bad++;
      $display("FAIL idle_before_first_byte: got err=%b cpu_r=%b rx_ready=%b, expected 0 1 1",
               err, cpu_r, rx_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    pay_q = '{8'hA9, 8'h05, 8'hEA};
    send_frame(16'h0200, "basic");
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    repeat (3) tick();
    rx_valid = 1'b0;
    total++;
    if ({rx_ready, done, cpu_r, err} !== 4'b0100) begin
      bad++;
      $display("FAIL run_ignores_input: got rx_ready=%b done=%b cpu_r=%b err=%b, expected 0 1 0 0",
               rx_ready, done, cpu_r, err);
    end
    check_drained("basic");
  endtask

  task automatic test_zero_len();
    do_reset();
    pay_q.delete();
    send_frame(16'h0010, "zero_len");
    check_drained("zero_len");
  endtask

  task automatic test_wrap();
    do_reset();
    pay_q = '{8'h11, 8'h22};
    send_frame(16'hFFFF, "wrap");
    check_drained("wrap");
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_err();
    do_reset();
    exp_q.push_back({16'h0200, 8'h01});
    exp_q.push_back({16'h0201, 8'h02});
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    total++;
    if ({err, cpu_r, done, rx_ready} !== 4'b1100) begin
      bad++;
      $display("FAIL checksum_err: got err=%b cpu_r=%b done=%b rx_ready=%b, expected 1 1 0 0",
               err, cpu_r, done, rx_ready);
    end
    send_byte(8'h33);
    send_byte(8'h44);
    check_drained("checksum_err");
  endtask
`endif

  task automatic test_timeout();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h02);
    repeat (3) tick();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: got err=%b after 3 idle cycles, expected 0", err);
    end
    tick();
    total++;
    if ({err, cpu_r, done, rx_ready} !== 4'b1100) begin
      bad++;
      $display("FAIL timeout_fire: got err=%b cpu_r=%b done=%b rx_ready=%b, expected 1 1 0 0",
               err, cpu_r, done, rx_ready);
    end
    send_byte(8'h03);
    send_byte(8'h00);
    total++;
    if ({err, done} !== 2'b10) begin
      bad++;
      $display("FAIL error_holds: got err=%b done=%b, expected 1 0", err, done);
    end
    check_drained("timeout");

    do_reset();
    send_byte(8'h00);
    send_byte(8'h02);
    repeat (3) tick();
    send_byte(8'h03);
    total++;
    if ({err, rx_ready} !== 2'b01) begin
      bad++;
      $display("FAIL timeout_rescued: got err=%b rx_ready=%b, expected 0 1", err, rx_ready);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h04); send_byte(8'h00);
    exp_q.push_back({16'h0300, 8'hC1});
    exp_q.push_back({16'h0301, 8'hC2});
    send_byte(8'hC1);
    send_byte(8'hC2);
    R = 1'b1;
    tick();
    total++;
    if ({mem_we, mem_addr, mem_din, cpu_r, done, err, rx_ready} !== RESET_VEC) begin
      bad++;
      $display("FAIL reset_mid_values: got %h, expected %h",
               {mem_we, mem_addr, mem_din, cpu_r, done, err, rx_ready}, RESET_VEC);
    end
    R = 1'b0;
    pay_q = '{8'h5A, 8'hA5};
    send_frame(16'h0400, "reset_mid");
    check_drained("reset_mid");
  endtask

  initial begin
    R        = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
`ifdef LOADER_CHECKSUM_EN
    test_checksum_err();
`endif
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
